// File: rtl/return_stack_pkg.sv
// Shared constants and the operation decode for the call/return stack.
// Holds the default stack depth and PC address width. The PC and
// return_stack both take these values so the two widths cannot drift apart.
package return_stack_pkg;

  localparam int RS_DEPTH = 8;
  localparam int PC_AW    = 16;

  // Operation requested in a cycle. The encoding is {pop, push}.
  typedef enum logic [1:0] {
    RS_IDLE = 2'b00,
    RS_PUSH = 2'b01,
    RS_POP  = 2'b10,
    RS_SWAP = 2'b11
  } rs_op_e;

  function automatic rs_op_e rs_decode(input logic push, input logic pop);
    return rs_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/return_stack_rs_mem.sv
// Storage array for the return stack: DEPTH x AW register file.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write index
//   wdata  - data written on the rising edge
//   raddr  - read index
//   rdata  - combinational read of raddr
// The contents are not reset. The owner's level pointer keeps stale
// entries out of reach until they are written again.
module rs_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack for CALL/RET.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - store push_addr (CALL)
//   push_addr  - return address to store
//   pop        - retrieve the top address (RET)
//   clr_err    - clear the sticky ovf/unf flags
//   pop_addr   - registered popped address; changes only on a successful pop
//   pop_valid  - one-cycle strobe after a successful pop
//   level      - current entry count
//   empty/full - level==0 / level==DEPTH
//   ovf/unf    - sticky overflow / underflow flags
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int AW    = PC_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [AW-1:0]          pop_addr,
  output logic                   pop_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   unf
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  logic [LW-1:0] r_level;
  logic [AW-1:0] r_pop_addr;
  logic          r_pop_valid;
  logic          r_ovf;
  logic          r_unf;

  rs_op_e        w_op;
  logic          w_empty;
  logic          w_full;
  logic [IW-1:0] w_top_idx;
  logic [AW-1:0] w_rd_data;
  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic [LW-1:0] w_level_nxt;
  logic          w_pop_ok;
  logic          w_set_ovf;
  logic          w_set_unf;

  assign w_op      = rs_decode(push, pop);
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  // The wrap at level 0 is harmless: the read result is discarded when empty.
  assign w_top_idx = r_level[IW-1:0] - IW'(1);

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_level[IW-1:0];
    w_level_nxt = r_level;
    w_pop_ok    = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    case (w_op)
      RS_PUSH: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_level_nxt = r_level + LW'(1);
        end
      end
      RS_POP: begin
        if (w_empty) begin
          w_set_unf = 1'b1;
        end else begin
          w_pop_ok    = 1'b1;
          w_level_nxt = r_level - LW'(1);
        end
      end
      RS_SWAP: begin
        w_we = 1'b1;
        if (w_empty) begin
          // Nothing to return. The push still lands as the first entry.
          w_set_unf   = 1'b1;
          w_waddr     = '0;
          w_level_nxt = LW'(1);
        end else begin
          // The old top is read combinationally before the write edge.
          // It is then replaced in place, so level does not change.
          w_pop_ok = 1'b1;
          w_waddr  = w_top_idx;
        end
      end
      default: ;
    endcase
  end

  rs_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (push_addr),
    .raddr (w_top_idx),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level     <= '0;
      r_pop_addr  <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_level     <= w_level_nxt;
      r_pop_valid <= w_pop_ok;
      if (w_pop_ok) r_pop_addr <= w_rd_data;
      // A new error in the same cycle as clr_err keeps the flag set.
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_unf <= w_set_unf | (r_unf & ~clr_err);
    end
  end

  assign pop_addr  = r_pop_addr;
  assign pop_valid = r_pop_valid;
  assign level     = r_level;
  assign empty     = w_empty;
  assign full      = w_full;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, clr_err;
  logic [15:0] push_addr;
  logic [15:0] pop_addr;
  logic        pop_valid;
  logic [3:0]  level;
  logic        empty, full, ovf, unf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [15:0] addr;
    logic [3:0]  e_level;
    logic        e_ovf;
    logic        e_unf;
    logic        e_pv;
    logic [15:0] e_addr;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] last_addr;

  return_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .clr_err   (clr_err),
    .pop_addr  (pop_addr),
    .pop_valid (pop_valid),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic q, input logic c, input logic [15:0] a,
                     input logic [3:0] l, input logic eo, input logic eu,
                     input logic pv, input logic [15:0] ea);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.addr = a;
    v.e_level = l; v.e_ovf = eo; v.e_unf = eu; v.e_pv = pv; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [15:0] exp_addr;
    push = v.push; pop = v.pop; clr_err = v.clr; push_addr = v.addr;
    if (v.e_pv) sb.push_back(v.e_addr);
    @(posedge clk);
    #1;
    chk({tag, " level"}, 32'(level), 32'(v.e_level));
    chk({tag, " pop_valid"}, 32'(pop_valid), 32'(v.e_pv));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.e_ovf));
    chk({tag, " unf"}, 32'(unf), 32'(v.e_unf));
    chk({tag, " empty"}, 32'(empty), 32'(v.e_level == 4'd0));
    chk({tag, " full"}, 32'(full), 32'(v.e_level == 4'd8));
    if (pop_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected pop_valid actual=1 expected=0 addr=%0h", tag, pop_addr);
      end else begin
        exp_addr = sb.pop_front();
        chk({tag, " pop_addr"}, 32'(pop_addr), 32'(exp_addr));
        last_addr = exp_addr;
      end
    end else begin
      chk({tag, " pop_addr held"}, 32'(pop_addr), 32'(last_addr));
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_addr = '0;
    last_addr = '0;

    // Swap cases (push and pop in the same cycle) are the 1'b1, 1'b1 rows.
    // push 0x11, 0x22, 0x33, then pop them back in reverse order
    add(1,0,0,16'h0011, 1,0,0,0,0);
    add(1,0,0,16'h0022, 2,0,0,0,0);
    add(1,0,0,16'h0033, 3,0,0,0,0);
    add(0,1,0,0, 2,0,0,1,16'h0033);
    add(0,1,0,0, 1,0,0,1,16'h0022);
    add(0,1,0,0, 0,0,0,1,16'h0011);
    // underflow from empty, then clear
    add(0,1,0,0, 0,0,1,0,0);
    add(0,0,1,0, 0,0,0,0,0);
    // fill, overflow, pop top, clear, drain
    for (int i = 0; i < 8; i++) add(1,0,0,16'h1000 + 16'(i), 4'(i+1),0,0,0,0);
    add(1,0,0,16'h2000, 8,1,0,0,0);
    add(0,1,0,0, 7,1,0,1,16'h1007);
    add(0,0,1,0, 7,0,0,0,0);
    for (int i = 6; i >= 0; i--) add(0,1,0,0, 4'(i),0,0,1,16'h1000 + 16'(i));
    // swap at level 2
    add(1,0,0,16'h0001, 1,0,0,0,0);
    add(1,0,0,16'h00AB, 2,0,0,0,0);
    add(1,1,0,16'h6AB3, 2,0,0,1,16'h00AB);
    add(0,1,0,0, 1,0,0,1,16'h6AB3);
    add(0,1,0,0, 0,0,0,1,16'h0001);
    // swap on empty
    add(1,1,0,16'h87AB, 1,0,1,0,0);
    add(0,1,0,0, 0,0,1,1,16'h87AB);
    add(0,0,1,0, 0,0,0,0,0);
    // swap when full does not overflow; clr_err with a new overflow keeps ovf set
    for (int i = 0; i < 8; i++) add(1,0,0,16'h3000 + 16'(i), 4'(i+1),0,0,0,0);
    add(1,1,0,16'h4000, 8,0,0,1,16'h3007);
    add(0,1,0,0, 7,0,0,1,16'h4000);
    add(1,0,0,16'h5000, 8,0,0,0,0);
    add(1,0,1,16'h6000, 8,1,0,0,0);
    add(0,0,1,0, 8,0,0,0,0);
    add(0,1,0,0, 7,0,0,1,16'h5000);
    for (int i = 6; i >= 3; i--) add(0,1,0,0, 4'(i),0,0,1,16'h3000 + 16'(i));

    // reset state, checked before any clock edge
    #3;
    chk("reset level", 32'(level), 0);
    chk("reset pop_valid", 32'(pop_valid), 0);
    chk("reset pop_addr", 32'(pop_addr), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset full", 32'(full), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset unf", 32'(unf), 0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset between edges, starting at level 3 with a pop strobe in flight.
    begin
      vec_t v;
      v.push = 0; v.pop = 1; v.clr = 0; v.addr = 0;
      v.e_level = 2; v.e_ovf = 0; v.e_unf = 0; v.e_pv = 1; v.e_addr = 16'h3002;
      apply(v, "pre_rst_pop");
      pop = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst level", 32'(level), 0);
      chk("async rst pop_valid", 32'(pop_valid), 0);
      chk("async rst pop_addr", 32'(pop_addr), 0);
      chk("async rst empty", 32'(empty), 1);
      #1 rst = 1'b0;
      last_addr = '0;
      v.pop = 1; v.e_level = 0; v.e_unf = 1; v.e_pv = 0; v.e_addr = 0;
      apply(v, "post_rst_pop");
    end

    chk("scoreboard drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stored return addresses (power of two, >=2).
REQ-002 SHALL have parameter AW, default 16, address width matching the PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port push  input  1  store push_addr (CALL executed).
REQ-006 SHALL have port push_addr  input  AW  return address to store, i.e. PC of the call plus one.
REQ-007 SHALL have port pop  input  1  retrieve the top address (RET executed; same cycle the PC's STACK_POP is asserted).
REQ-008 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-009 SHALL have port pop_addr  output  AW  popped address, driven to the PC's load input.
REQ-010 SHALL have port pop_valid  output  1  one-cycle strobe: pop_addr is valid.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-012 SHALL have ports empty and full, each output 1, meaning level==0 and level==DEPTH respectively.
REQ-013 SHALL have ports ovf and unf, each output 1, sticky overflow and underflow flags.

Function
REQ-014 Push with level<DEPTH, no pop, SHALL write push_addr at index level and increment level.
REQ-015 Pop with level>0, no push, SHALL register mem[level-1] into pop_addr, assert pop_valid for exactly the next cycle, and decrement level.
REQ-016 Pop latency SHALL be 1 cycle: edge N samples pop; pop_addr/pop_valid are valid from edge N to edge N+1.
REQ-017 Simultaneous push and pop with level>0 SHALL output the old top as in REQ-015, overwrite the top entry with push_addr, and leave level unchanged.
REQ-018 Simultaneous push and pop with level==0 SHALL set unf, not assert pop_valid, write push_addr at index 0, and set level to 1.
REQ-019 Push with level==DEPTH (no pop) SHALL drop the data, set ovf, and leave level and contents unchanged.
REQ-020 Pop with level==0 (no push) SHALL set unf, leave pop_valid low and pop_addr holding its previous value.
REQ-021 Simultaneous push and pop at level==DEPTH SHALL behave as REQ-017, with no overflow.
REQ-022 ovf/unf SHALL remain set until clr_err or reset; clr_err in the same cycle as a new error SHALL leave the flag set (set wins).
REQ-023 pop_valid SHALL be low in every cycle not following a successful pop; pop_addr SHALL change only on a successful pop.
REQ-024 empty, full, and level SHALL be combinational from the level register.

Reset
REQ-025 rst high SHALL immediately force level=0, pop_addr=0, pop_valid=0, ovf=0, unf=0, independent of clk.
REQ-026 Storage contents need not be reset; entries SHALL be unreachable until rewritten.
REQ-027 Reset asserted mid-operation SHALL abort any pending pop strobe; the first edge after rst falls SHALL process inputs normally.

Structure
REQ-028 A shared package SHALL hold the default DEPTH and AW constants, used by both PC and return_stack.
REQ-029 Storage SHALL be one sub-module, rs_mem: a DEPTH x AW register file with one synchronous write port and one combinational read port; return_stack holds the pointer, flags, and output registers.

Verification
REQ-030 Reset, then push 0x0011, 0x0022, 0x0033; pop three times -> pop_addr 0x0033, 0x0022, 0x0011, each with a 1-cycle pop_valid; level 3->0; empty=1.
REQ-031 From empty, pop -> unf=1, pop_valid=0, pop_addr unchanged; clr_err -> unf=0.
REQ-032 Push 0x1000..0x1007 (8 entries) -> full=1; push 0x2000 -> ovf=1, level=8; pop -> 0x1007.
REQ-033 level=2 with top 0x00AB; push 0x6AB3 and pop together -> pop_addr=0x00AB, level=2; next pop -> 0x6AB3.
REQ-034 Empty; push 0x87AB and pop together -> unf=1, pop_valid=0, level=1; next pop -> 0x87AB.
REQ-035 level=3; assert rst between edges -> level=0 and pop_valid=0 at once, without a clock edge; after release, a pop sets unf.
